// File: rtl/result_monitor_if.sv
// Data-memory write bus as seen by the result monitor.
// The master drives address, data and write enable; the monitor only observes.
interface result_monitor_if #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              wen;

  modport master (output addr, output data, output wen);
  modport slave  (input  addr, input  data, input  wen);
endinterface

// File: rtl/result_monitor.sv
// Self-checking result monitor for CPU/cache system benches.
// Watches the data-memory write bus. A begin-symbol write to the test port
// arms a run. Each later distinct test-port write is compared against an
// external expected-value table, indexed by exp_idx. The block counts
// mismatches and CHECK cycles, keeps the first failure, and holds a
// PASS/FAIL/TIMEOUT/SHORT report until cleared.
module result_monitor #(
  parameter int unsigned              ADDR_W      = 30,
  parameter int unsigned              DATA_W      = 32,
  parameter logic [ADDR_W-1:0]        TEST_PORT   = 'h40,
  parameter logic [DATA_W-1:0]        BEGIN_SYM   = 'h932,
  parameter logic [DATA_W-1:0]        END_SYM     = 'hD5D,
  parameter int unsigned              NUM_CHECKS  = 61,
  parameter int unsigned              IDX_W       = 6,
  parameter int unsigned              ERR_W       = 8,
  parameter int unsigned              DUR_W       = 16,
  parameter logic [DUR_W-1:0]         TIMEOUT_CYC = 'hFFFF
) (
  input  logic               clk,
  input  logic               rst,
  result_monitor_if.slave    bus,
  input  logic               clear,
  output logic [IDX_W-1:0]   exp_idx,
  input  logic [DATA_W-1:0]  exp_data,
  output logic [ERR_W-1:0]   error_num,
  output logic [DUR_W-1:0]   duration,
  output logic               finish,
  output logic [1:0]         status,
  output logic               first_err_valid,
  output logic [IDX_W-1:0]   first_err_idx,
  output logic [DATA_W-1:0]  first_err_got,
  output logic [DATA_W-1:0]  first_err_exp
);

  // Control states
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  // Report codes
  localparam logic [1:0] ST_PASS    = 2'd0;
  localparam logic [1:0] ST_FAIL    = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_SHORT   = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);
  localparam logic [DUR_W-1:0] TO_LAST  = TIMEOUT_CYC - DUR_W'(1);
  localparam bit               TO_EN    = (TIMEOUT_CYC != '0);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [1:0]       status_next;
  logic             armed;
  logic             accept;
  logic             in_check;
  logic             score;
  logic             hit_begin;
  logic             hit_short;
  logic             hit_timeout;
  logic             done_full;
  logic             err_hit;
  logic [ERR_W-1:0] err_next;
  logic [DUR_W-1:0] dur_next;

  // Write qualification: a write held high across stall cycles is taken once,
  // because any cycle with wen=1 disarms until wen drops again.
  always_comb begin
    accept    = bus.wen & armed & (bus.addr == TEST_PORT);
    in_check  = (state == S_CHECK);
    score     = in_check & accept;
    hit_begin = (state == S_IDLE) & accept & (bus.data == BEGIN_SYM);
  end

  // Scoring and termination conditions for the current CHECK cycle
  always_comb begin
    done_full   = score & (exp_idx == LAST_IDX);
    hit_short   = score & (bus.data == END_SYM) & (exp_idx < LAST_IDX);
    // An early terminal symbol is a mismatch even if the table happened to hold it
    err_hit     = score & ((bus.data != exp_data) | hit_short);
    hit_timeout = TO_EN & in_check & (duration == TO_LAST);
    err_next    = (err_hit && (error_num != '1)) ? error_num + ERR_W'(1) : error_num;
    dur_next    = (duration != '1) ? duration + DUR_W'(1) : duration;
  end

  // Report code chosen on the way into REPORT: completion > SHORT > TIMEOUT
  always_comb begin
    status_next = status;
    if (done_full) begin
      status_next = (err_next == '0) ? ST_PASS : ST_FAIL;
    end else if (hit_short) begin
      status_next = ST_SHORT;
    end else if (hit_timeout) begin
      status_next = ST_TIMEOUT;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (hit_begin) state_next = S_CHECK;
      end
      S_CHECK: begin
        if (done_full || hit_short || hit_timeout) state_next = S_REPORT;
      end
      S_REPORT: begin
        if (clear) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Report flag is a pure decode of the state register
  always_comb begin
    finish = (state == S_REPORT);
  end

  // Edge detector on the write enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed <= 1'b1;
    end else begin
      armed <= ~bus.wen;
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Run counters and report code; frozen outside CHECK except at arm time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      error_num <= '1;
      duration  <= '0;
      exp_idx   <= '0;
      status    <= ST_PASS;
    end else if (hit_begin) begin
      error_num <= '0;
      duration  <= '0;
      exp_idx   <= '0;
      status    <= ST_PASS;
    end else if (in_check) begin
      duration  <= dur_next;
      error_num <= err_next;
      if (score) begin
        exp_idx <= exp_idx + IDX_W'(1);
      end
      if (state_next == S_REPORT) begin
        status <= status_next;
      end
    end
  end

  // First-failure capture; only the earliest mismatch of a run is kept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_got   <= '0;
      first_err_exp   <= '0;
    end else if (hit_begin) begin
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_got   <= '0;
      first_err_exp   <= '0;
    end else if (err_hit && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_idx   <= exp_idx;
      first_err_got   <= bus.data;
      first_err_exp   <= exp_data;
    end
  end

endmodule

// File: tb/tb_result_monitor.sv
// Directed bench for result_monitor: Fibonacci result table, stalls,
// corruption, early end, timeout, mid-run reset, clear sequencing and
// error-counter saturation.
module tb_result_monitor;

  localparam logic [29:0] TP   = 30'h40;
  localparam logic [31:0] BSYM = 32'h932;
  localparam logic [31:0] ESYM = 32'hD5D;

  logic clk;
  logic rst;
  logic clear;

  int checks;
  int failures;

  logic [31:0] fib [0:63];

  result_monitor_if #(.ADDR_W(30), .DATA_W(32)) bus_if ();

  // Main instance: default configuration
  logic [5:0]  exp_idx;
  logic [31:0] exp_data;
  logic [7:0]  error_num;
  logic [15:0] duration;
  logic        finish;
  logic [1:0]  status;
  logic        fev;
  logic [5:0]  fe_idx;
  logic [31:0] fe_got;
  logic [31:0] fe_exp;

  assign exp_data = fib[exp_idx];

  result_monitor u_dut (
    .clk(clk), .rst(rst), .bus(bus_if.slave), .clear(clear),
    .exp_idx(exp_idx), .exp_data(exp_data), .error_num(error_num),
    .duration(duration), .finish(finish), .status(status),
    .first_err_valid(fev), .first_err_idx(fe_idx),
    .first_err_got(fe_got), .first_err_exp(fe_exp)
  );

  // Short-timeout instance
  logic [5:0]  to_idx;
  logic [31:0] to_exp_data;
  logic [7:0]  to_err;
  logic [15:0] to_dur;
  logic        to_finish;
  logic [1:0]  to_status;
  logic        to_fev;
  logic [5:0]  to_fe_idx;
  logic [31:0] to_fe_got;
  logic [31:0] to_fe_exp;

  assign to_exp_data = fib[to_idx];

  result_monitor #(.TIMEOUT_CYC(16'd100)) u_to (
    .clk(clk), .rst(rst), .bus(bus_if.slave), .clear(clear),
    .exp_idx(to_idx), .exp_data(to_exp_data), .error_num(to_err),
    .duration(to_dur), .finish(to_finish), .status(to_status),
    .first_err_valid(to_fev), .first_err_idx(to_fe_idx),
    .first_err_got(to_fe_got), .first_err_exp(to_fe_exp)
  );

  // Long-run instance for error counter saturation
  logic [8:0]  s_idx;
  logic [31:0] s_exp_data;
  logic [7:0]  s_err;
  logic [15:0] s_dur;
  logic        s_finish;
  logic [1:0]  s_status;
  logic        s_fev;
  logic [8:0]  s_fe_idx;
  logic [31:0] s_fe_got;
  logic [31:0] s_fe_exp;

  assign s_exp_data = 32'h1234;

  result_monitor #(.NUM_CHECKS(300), .IDX_W(9)) u_sat (
    .clk(clk), .rst(rst), .bus(bus_if.slave), .clear(clear),
    .exp_idx(s_idx), .exp_data(s_exp_data), .error_num(s_err),
    .duration(s_dur), .finish(s_finish), .status(s_status),
    .first_err_valid(s_fev), .first_err_idx(s_fe_idx),
    .first_err_got(s_fe_got), .first_err_exp(s_fe_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear = 1'b0;
    bus_if.wen = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Starts and ends on a falling edge; one wen=0 gap cycle after the write
  task automatic bus_write(input logic [29:0] a, input logic [31:0] d, input int hold);
    bus_if.addr = a;
    bus_if.data = d;
    bus_if.wen  = 1'b1;
    repeat (hold) @(negedge clk);
    bus_if.wen  = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_fib(input int hold, input int bad_idx, input logic [31:0] bad_val);
    bus_write(TP, BSYM, 1);
    for (int i = 0; i < 61; i++) begin
      bus_write(TP, (i == bad_idx) ? bad_val : fib[i], hold);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    clear = 1'b0;
    bus_if.wen = 1'b0;
    bus_if.addr = '0;
    bus_if.data = '0;
    #1;
    checks++; if (error_num !== 8'hFF) begin failures++; $display("FAIL reset_err got=%0h exp=ff", error_num); end
    checks++; if (duration !== 16'd0) begin failures++; $display("FAIL reset_dur got=%0d exp=0", duration); end
    checks++; if (finish !== 1'b0) begin failures++; $display("FAIL reset_finish got=%b exp=0", finish); end
    checks++; if (status !== 2'd0) begin failures++; $display("FAIL reset_status got=%0d exp=0", status); end
    checks++; if (exp_idx !== 6'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", exp_idx); end
    checks++; if ({fev, fe_idx, fe_got, fe_exp} !== '0) begin failures++; $display("FAIL reset_first_err got=%b/%0d/%0h/%0h exp=0", fev, fe_idx, fe_got, fe_exp); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean();
    do_reset();
    run_fib(1, -1, 32'd0);
    checks++; if (finish !== 1'b1) begin failures++; $display("FAIL clean_finish got=%b exp=1", finish); end
    checks++; if (status !== 2'd0) begin failures++; $display("FAIL clean_status got=%0d exp=0", status); end
    checks++; if (error_num !== 8'd0) begin failures++; $display("FAIL clean_err got=%0d exp=0", error_num); end
    checks++; if (fev !== 1'b0) begin failures++; $display("FAIL clean_fev got=%b exp=0", fev); end
    checks++; if (duration !== 16'd122) begin failures++; $display("FAIL clean_dur got=%0d exp=122", duration); end
    checks++; if (exp_idx !== 6'd61) begin failures++; $display("FAIL clean_idx got=%0d exp=61", exp_idx); end
  endtask

  task automatic test_stall();
    do_reset();
    run_fib(3, -1, 32'd0);
    checks++; if (finish !== 1'b1) begin failures++; $display("FAIL stall_finish got=%b exp=1", finish); end
    checks++; if (status !== 2'd0) begin failures++; $display("FAIL stall_status got=%0d exp=0", status); end
    checks++; if (exp_idx !== 6'd61) begin failures++; $display("FAIL stall_idx got=%0d exp=61", exp_idx); end
    checks++; if (error_num !== 8'd0) begin failures++; $display("FAIL stall_err got=%0d exp=0", error_num); end
    checks++; if (duration !== 16'd242) begin failures++; $display("FAIL stall_dur got=%0d exp=242", duration); end
  endtask

  task automatic test_corrupt();
    do_reset();
    run_fib(1, 10, 32'd56);
    checks++; if (status !== 2'd1) begin failures++; $display("FAIL corrupt_status got=%0d exp=1", status); end
    checks++; if (error_num !== 8'd1) begin failures++; $display("FAIL corrupt_err got=%0d exp=1", error_num); end
    checks++; if (fev !== 1'b1) begin failures++; $display("FAIL corrupt_fev got=%b exp=1", fev); end
    checks++; if (fe_idx !== 6'd10) begin failures++; $display("FAIL corrupt_fe_idx got=%0d exp=10", fe_idx); end
    checks++; if (fe_got !== 32'd56) begin failures++; $display("FAIL corrupt_fe_got got=%0d exp=56", fe_got); end
    checks++; if (fe_exp !== 32'd55) begin failures++; $display("FAIL corrupt_fe_exp got=%0d exp=55", fe_exp); end
  endtask

  // Continues from the FAIL report left by test_corrupt
  task automatic test_clear();
    bus_write(TP, BSYM, 1);
    checks++; if (finish !== 1'b1 || exp_idx !== 6'd61) begin failures++; $display("FAIL report_ignores_bus got=%b/%0d exp=1/61", finish, exp_idx); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (finish !== 1'b0) begin failures++; $display("FAIL clear_finish got=%b exp=0", finish); end
    checks++; if (error_num !== 8'd1 || fev !== 1'b1 || status !== 2'd1) begin failures++; $display("FAIL clear_hold got=%0d/%b/%0d exp=1/1/1", error_num, fev, status); end
    bus_write(30'h41, BSYM, 1);
    checks++; if (exp_idx !== 6'd61 || duration !== 16'd122) begin failures++; $display("FAIL idle_other_addr got=%0d/%0d exp=61/122", exp_idx, duration); end
    bus_write(TP, BSYM, 1);
    checks++; if (error_num !== 8'd0 || fev !== 1'b0 || exp_idx !== 6'd0 || finish !== 1'b0) begin failures++; $display("FAIL rearm got=%0d/%b/%0d/%b exp=0/0/0/0", error_num, fev, exp_idx, finish); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    bus_write(TP, fib[0], 1);
    checks++; if (exp_idx !== 6'd1 || finish !== 1'b0 || error_num !== 8'd0) begin failures++; $display("FAIL check_ignores_clear got=%0d/%b/%0d exp=1/0/0", exp_idx, finish, error_num); end
  endtask

  task automatic test_short();
    do_reset();
    bus_write(TP, BSYM, 1);
    for (int i = 0; i < 20; i++) bus_write(TP, fib[i], 1);
    bus_if.addr = TP;
    bus_if.data = ESYM;
    bus_if.wen  = 1'b1;
    checks++; if (finish !== 1'b0) begin failures++; $display("FAIL short_pre_finish got=%b exp=0", finish); end
    @(negedge clk);
    bus_if.wen = 1'b0;
    checks++; if (finish !== 1'b1) begin failures++; $display("FAIL short_latency got=%b exp=1", finish); end
    checks++; if (status !== 2'd3) begin failures++; $display("FAIL short_status got=%0d exp=3", status); end
    checks++; if (error_num !== 8'd1) begin failures++; $display("FAIL short_err got=%0d exp=1", error_num); end
    checks++; if (fe_idx !== 6'd20 || fe_got !== ESYM || fe_exp !== 32'd6765) begin failures++; $display("FAIL short_first_err got=%0d/%0h/%0d exp=20/d5d/6765", fe_idx, fe_got, fe_exp); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus_write(TP, BSYM, 1);
    for (int i = 0; i < 30; i++) bus_write(TP, fib[i], 1);
    bus_if.addr = TP;
    bus_if.data = fib[30];
    bus_if.wen  = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++; if (error_num !== 8'hFF || duration !== 16'd0 || exp_idx !== 6'd0) begin failures++; $display("FAIL midreset_counters got=%0h/%0d/%0d exp=ff/0/0", error_num, duration, exp_idx); end
    checks++; if (finish !== 1'b0 || status !== 2'd0 || fev !== 1'b0) begin failures++; $display("FAIL midreset_flags got=%b/%0d/%b exp=0/0/0", finish, status, fev); end
    @(negedge clk);
    bus_if.wen = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    bus_write(TP, BSYM, 1);
    bus_write(TP, 32'd7, 1);
    checks++; if (exp_idx !== 6'd1 || error_num !== 8'd1) begin failures++; $display("FAIL midreset_rerun got=%0d/%0d exp=1/1", exp_idx, error_num); end
    checks++; if (fe_idx !== 6'd0 || fe_got !== 32'd7 || fe_exp !== 32'd0) begin failures++; $display("FAIL midreset_first_err got=%0d/%0d/%0d exp=0/7/0", fe_idx, fe_got, fe_exp); end
  endtask

  task automatic test_timeout();
    do_reset();
    bus_write(TP, BSYM, 1);
    for (int n = 0; n < 200 && !to_finish; n++) @(negedge clk);
    checks++; if (to_finish !== 1'b1) begin failures++; $display("FAIL timeout_finish got=%b exp=1", to_finish); end
    checks++; if (to_status !== 2'd2) begin failures++; $display("FAIL timeout_status got=%0d exp=2", to_status); end
    checks++; if (to_dur !== 16'd100) begin failures++; $display("FAIL timeout_dur got=%0d exp=100", to_dur); end
    checks++; if (to_err !== 8'd0 || to_idx !== 6'd0) begin failures++; $display("FAIL timeout_counts got=%0d/%0d exp=0/0", to_err, to_idx); end
  endtask

  task automatic test_saturate();
    do_reset();
    bus_write(TP, BSYM, 1);
    for (int i = 0; i < 254; i++) bus_write(TP, 32'd0, 1);
    checks++; if (s_err !== 8'd254) begin failures++; $display("FAIL sat_count got=%0d exp=254", s_err); end
    for (int i = 254; i < 300; i++) bus_write(TP, 32'd0, 1);
    checks++; if (s_err !== 8'd255) begin failures++; $display("FAIL sat_err got=%0d exp=255", s_err); end
    checks++; if (s_finish !== 1'b1 || s_status !== 2'd1 || s_idx !== 9'd300) begin failures++; $display("FAIL sat_report got=%b/%0d/%0d exp=1/1/300", s_finish, s_status, s_idx); end
    checks++; if (s_fe_idx !== 9'd0 || s_fe_exp !== 32'h1234) begin failures++; $display("FAIL sat_first_err got=%0d/%0h exp=0/1234", s_fe_idx, s_fe_exp); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) fib[i] = 32'd0;
    fib[1] = 32'd1;
    for (int i = 2; i < 30; i++) fib[i] = fib[i-1] + fib[i-2];
    for (int i = 30; i < 60; i++) fib[i] = fib[59-i];
    fib[60] = ESYM;
    rst = 1'b1;
    clear = 1'b0;
    bus_if.wen = 1'b0;
    bus_if.addr = '0;
    bus_if.data = '0;

    test_reset();
    test_clean();
    test_stall();
    test_corrupt();
    test_clear();
    test_short();
    test_reset_mid();
    test_timeout();
    test_saturate();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_monitor.md
Name: result_monitor

Overview:
- Parametrised self-checking result monitor for CPU/cache system benches; sits beside the DUT on the data-memory write bus.
- Arms on a begin-symbol write to the test port, then compares each distinct test-port write against an external expected-value table.
- Counts mismatches and cycles, captures the first failure, and reports PASS / FAIL / TIMEOUT / SHORT.
- Stall-tolerant: a write held across multiple cycles is counted once.

Parameters:
ADDR_W, 30, bus address width (word address)
DATA_W, 32, bus data width
TEST_PORT, 30'h40, word address of the result port
BEGIN_SYM, 32'h932, data value that arms checking
END_SYM, 32'hD5D, terminal value; the last expected entry
NUM_CHECKS, 61, number of writes compared per run
IDX_W, 6, index width; must satisfy 2^IDX_W > NUM_CHECKS
ERR_W, 8, error counter width
DUR_W, 16, duration counter width
TIMEOUT_CYC, 16'hFFFF, cycles in CHECK before forced report; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
addr  in  ADDR_W  bus write address
data  in  DATA_W  bus write data
wen  in  1  bus write enable (may be held high during stalls)
clear  in  1  synchronous return to IDLE from REPORT
exp_idx  out  IDX_W  index into the expected table (= current check index)
exp_data  in  DATA_W  expected value for exp_idx; combinational, valid in the same cycle
error_num  out  ERR_W  mismatch count
duration  out  DUR_W  cycles spent in CHECK
finish  out  1  high while in REPORT
status  out  2  0 PASS, 1 FAIL, 2 TIMEOUT, 3 SHORT; meaningful only when finish=1
first_err_valid  out  1  a mismatch has been captured
first_err_idx  out  IDX_W  index of the first mismatch
first_err_got  out  DATA_W  data observed at the first mismatch
first_err_exp  out  DATA_W  expected value at the first mismatch

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; error_num=all-ones; duration=0; finish=0; status=0; exp_idx=0.
  - first_err_* =0; edge detector armed.
- Write qualification:
  - accept = wen & armed & (addr==TEST_PORT).
  - armed clears on any cycle with wen=1 and re-sets on the first cycle with wen=0.
  - A multi-cycle held write is therefore accepted once, on its first cycle.
  - Writes to other addresses also disarm, so back-to-back held writes need a wen=0 gap between them.
- IDLE:
  - On accept with data==BEGIN_SYM: go to CHECK; error_num<=0; duration<=0; exp_idx<=0; clear first_err_*.
  - Any other write is ignored.
- CHECK:
  - duration increments every cycle, saturating at all-ones.
  - On accept:
    - If data!=exp_data: error_num increments, saturating at all-ones.
    - If no first error is captured yet, capture idx/got/exp and set first_err_valid.
    - exp_idx increments.
  - Completion: the accept at exp_idx==NUM_CHECKS-1 moves the next state to REPORT.
    - status = PASS if the final error_num==0, else FAIL.
  - Early end: an accept with data==END_SYM and exp_idx<NUM_CHECKS-1 is counted as a mismatch, then the block goes to REPORT with status=SHORT.
  - Timeout: when TIMEOUT_CYC!=0 and duration==TIMEOUT_CYC-1 with no completing accept that cycle, go to REPORT with status=TIMEOUT.
  - Priority within one cycle: completion > SHORT > TIMEOUT. The accept in that cycle is always scored.
  - BEGIN_SYM seen in CHECK is scored as ordinary data; there is no restart.
- REPORT:
  - finish=1. All counters, status and first_err_* are frozen.
  - Bus writes are ignored.
  - clear=1 returns to IDLE; outputs hold until the next BEGIN_SYM.
  - clear is ignored in IDLE and CHECK.
- Latency: finish asserts on the clock edge after the completing or terminating accept.
- Reset mid-run: returns immediately to reset values; no partial report.
- No simulation-only constructs in the block. Pass/fail messages belong to the enclosing bench.

Test Plan:
- Clean Fibonacci run: BEGIN write to 0x40, then 61 single-cycle writes of 0,1,1,2,…,514229,514229,…,1,0,0xD5D, each followed by a wen=0 gap -> finish=1, status=PASS, error_num=0, first_err_valid=0.
- Stall dedup: same run but every write holds wen high for 3 cycles -> still exactly 61 accepts, status=PASS, and duration is larger than in the clean run.
- Single corruption: value at index 10 written as 56 instead of 55 -> status=FAIL, error_num=1, first_err_idx=10, got=56, exp=55.
- Early end: 0xD5D written at index 20 -> status=SHORT, error_num=1, finish one cycle after that write.
- Timeout: TIMEOUT_CYC=100, BEGIN then silence -> status=TIMEOUT, duration=100, error_num=0.
- Async reset at index 30 mid-run, then clear/BEGIN sequencing and the error counter saturating at 255 (ERR_W=8, NUM_CHECKS>255 configuration) -> outputs return to reset values; the new run scores from index 0.
